// File: rtl/io_pkg.sv
// Shared types for the device-side FGI/FGO programmed-I/O port.
// Holds the byte width and the state encodings of the input and output handshake FSMs.
package io_pkg;

  localparam int IO_W = 8;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_WAIT_SET,
    IN_WAIT_CLR
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_SEND,
    OUT_PACE,
    OUT_WAIT_SET
  } out_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Small single-clock FIFO with a combinational head read, so a pop can load the head in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module io_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign head    = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/io_device_port.sv
// Device end of the FGI/FGO handshake: feeds bytes from a source into INPR and
// drains OUTR to a sink, pacing the FGO re-set after each delivered byte.
module io_device_port
  import io_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DELAY = 3,
  parameter int CW        = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fgi,
  input  logic            fgo,
  input  logic [IO_W-1:0] outr,
  output logic            set_fgi,
  output logic            set_fgo,
  output logic [IO_W-1:0] inpr,
  input  logic            in_valid,
  input  logic [IO_W-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [IO_W-1:0] out_data,
  input  logic            out_ready
);

  // ---------------- input direction ----------------
  in_state_t       in_state_reg;
  in_state_t       in_state_next;
  logic [IO_W-1:0] inpr_reg;
  logic            load;
  logic            fifo_full;
  logic            fifo_empty;
  logic [IO_W-1:0] fifo_head;

  io_sync_fifo #(
    .W     (IO_W),
    .DEPTH (IN_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (load),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign in_ready = !fifo_full;

  always_comb begin
    in_state_next = in_state_reg;
    load          = 1'b0;
    case (in_state_reg)
      IN_IDLE: begin
        if (!fifo_empty && !fgi) begin
          load          = 1'b1;
          in_state_next = IN_WAIT_SET;
        end
      end
      // A low fgi here only means the datapath has not registered the set yet.
      IN_WAIT_SET: if (fgi)  in_state_next = IN_WAIT_CLR;
      IN_WAIT_CLR: if (!fgi) in_state_next = IN_IDLE;
      default:     in_state_next = IN_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_state_reg <= IN_IDLE;
      inpr_reg     <= '0;
    end else begin
      in_state_reg <= in_state_next;
      if (load) begin
        inpr_reg <= fifo_head;
      end
    end
  end

  assign set_fgi = load;
  assign inpr    = inpr_reg;

  // ---------------- output direction ----------------
  out_state_t      out_state_reg;
  out_state_t      out_state_next;
  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   cnt_next;
  logic            out_valid_reg;
  logic            out_valid_next;
  logic [IO_W-1:0] out_data_reg;
  logic [IO_W-1:0] out_data_next;
  logic            fgo_pulse;

  always_comb begin
    out_state_next = out_state_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    fgo_pulse      = 1'b0;
    case (out_state_reg)
      OUT_IDLE: begin
        if (!fgo) begin
          out_data_next  = outr;
          out_valid_next = 1'b1;
          out_state_next = OUT_SEND;
        end
      end
      OUT_SEND: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          cnt_next       = CW'(OUT_DELAY);
          out_state_next = OUT_PACE;
        end
      end
      OUT_PACE: begin
        if (cnt_reg == '0) begin
          fgo_pulse      = 1'b1;
          out_state_next = OUT_WAIT_SET;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      OUT_WAIT_SET: if (fgo) out_state_next = OUT_IDLE;
      default:      out_state_next = OUT_IDLE;
    endcase
  end

  // Reset lands in OUT_PACE with a zero count so the "printer ready" pulse follows release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_state_reg <= OUT_PACE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_state_reg <= out_state_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  // The reset state would otherwise request FGO while reset is still held.
  assign set_fgo   = fgo_pulse && reset;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule
